// File: rtl/responder_arbiter.sv
// Quiz-show responder arbiter: debounced buttons, first-press lock-out, answer countdown, song trigger.
// Optional macro RESPONDER_FALSE_START_EN adds per-player false-start flags armed from IDLE presses.
module responder_arbiter #(
   parameter int TICK_DIV    = 100000,
   parameter int DEB_MS      = 10,
   parameter int PLAY_MS     = 2000,
   parameter int TICKS_PER_S = 1000,
   parameter int WINDOW_S    = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_clear,
   input  logic [3:0] player_btn,
   output logic       play_en,
   output logic [3:0] winner,
   output logic       winner_valid,
   output logic       armed,
   output logic       timeout,
   output logic [3:0] countdown,
   output logic [3:0] false_start
);

   localparam int NIN    = 6;
   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DEB_W  = $clog2(DEB_MS + 1);
   localparam int SEC_W  = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
   localparam int PLAY_W = (PLAY_MS > 1) ? $clog2(PLAY_MS) : 1;
   localparam logic [3:0] WINDOW_INIT = 4'(WINDOW_S);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_WON,
      ST_DONE,
      ST_TOUT
   } state_t;

   // ---------------------------------------------------------------- tick divider
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      tick  = (div_q == DIV_W'(TICK_DIV - 1));
      div_d = tick ? '0 : div_q + DIV_W'(1);
   end

   // ---------------------------------------------------------------- synchronise + debounce
   logic [NIN-1:0]   raw, sync1_q, sync2_q;
   logic [NIN-1:0]   deb_q, deb_d, deb_dly_q, rise;
   logic [DEB_W-1:0] deb_cnt_q [NIN];
   logic [DEB_W-1:0] deb_cnt_d [NIN];
   logic [3:0]       p_rise;
   logic             start_rise, clear_rise;

   assign raw = {btn_clear, btn_start, player_btn};

   // A level flips only after DEB_MS consecutive ticks of a differing input; any agreement restarts the run.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NIN; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (tick) begin
            if (deb_cnt_q[i] == DEB_W'(DEB_MS - 1)) begin
               deb_cnt_d[i] = '0;
               deb_d[i]     = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   assign rise       = deb_q & ~deb_dly_q;
   assign p_rise     = rise[3:0];
   assign start_rise = rise[4];
   assign clear_rise = rise[5];

   // ---------------------------------------------------------------- round control
   state_t            state_q, state_d;
   logic [3:0]        winner_q, winner_d;
   logic [3:0]        cd_q, cd_d;
   logic [SEC_W-1:0]  sec_q, sec_d;
   logic [PLAY_W-1:0] play_q, play_d;
   logic [3:0]        eligible, first_hot;

`ifdef RESPONDER_FALSE_START_EN
   logic [3:0] fs_q, fs_d;

   assign eligible    = p_rise & ~fs_q;
   assign false_start = fs_q;

   always_comb begin
      fs_d = fs_q;
      if (clear_rise) begin
         fs_d = '0;
      end else if (state_q == ST_IDLE) begin
         fs_d = fs_q | p_rise;
      end
   end
`else
   assign eligible    = p_rise;
   assign false_start = '0;
`endif

   // Isolating the lowest set bit gives the lowest-index winner on simultaneous presses.
   assign first_hot = eligible & (~eligible + 4'd1);

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      cd_d     = cd_q;
      sec_d    = sec_q;
      play_d   = play_q;

      if (clear_rise) begin
         state_d  = ST_IDLE;
         winner_d = '0;
         cd_d     = '0;
         sec_d    = '0;
         play_d   = '0;
      end else if (start_rise &&
                   (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_TOUT)) begin
         state_d  = ST_ARMED;
         winner_d = '0;
         cd_d     = WINDOW_INIT;
         sec_d    = '0;
      end else begin
         case (state_q)
            ST_ARMED: begin
               // A press beats the countdown expiring in the same cycle.
               if (|eligible) begin
                  winner_d = first_hot;
                  play_d   = '0;
                  state_d  = ST_WON;
               end else if (tick) begin
                  if (sec_q == SEC_W'(TICKS_PER_S - 1)) begin
                     sec_d = '0;
                     cd_d  = cd_q - 4'd1;
                     if (cd_q == 4'd1) begin
                        state_d = ST_TOUT;
                     end
                  end else begin
                     sec_d = sec_q + SEC_W'(1);
                  end
               end
            end
            ST_WON: begin
               if (tick) begin
                  if (play_q == PLAY_W'(PLAY_MS - 1)) begin
                     play_d  = '0;
                     state_d = ST_DONE;
                  end else begin
                     play_d = play_q + PLAY_W'(1);
                  end
               end
            end
            ST_IDLE, ST_DONE, ST_TOUT: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- registers
   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q     <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         // NOTE: the debounce counter array is reset element by element; a button held through reset must start from zero.
         for (int i = 0; i < NIN; i++) begin
            deb_cnt_q[i] <= '0;
         end
         state_q   <= ST_IDLE;
         winner_q  <= '0;
         cd_q      <= '0;
         sec_q     <= '0;
         play_q    <= '0;
`ifdef RESPONDER_FALSE_START_EN
         fs_q      <= '0;
`endif
      end else begin
         div_q     <= div_d;
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         for (int i = 0; i < NIN; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         state_q   <= state_d;
         winner_q  <= winner_d;
         cd_q      <= cd_d;
         sec_q     <= sec_d;
         play_q    <= play_d;
`ifdef RESPONDER_FALSE_START_EN
         fs_q      <= fs_d;
`endif
      end
   end

   assign play_en      = (state_q == ST_WON);
   assign armed        = (state_q == ST_ARMED);
   assign winner_valid = (state_q == ST_WON) || (state_q == ST_DONE);
   assign timeout      = (state_q == ST_TOUT);
   assign winner       = winner_q;
   assign countdown    = cd_q;

endmodule

// File: tb/tb_responder_arbiter.sv
// Bench for responder_arbiter: directed scenarios plus random presses, checked every cycle against a round-level model.
module tb_responder_arbiter;

   localparam int TD  = 10;
   localparam int DEB = 2;
   localparam int PLY = 5;
   localparam int TPS = 4;
   localparam int WIN = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_start, btn_clear;
   logic [3:0] player_btn;
   logic       play_en, winner_valid, armed, timeout;
   logic [3:0] winner, countdown, false_start;

   int  n_pass  = 0;
   int  n_check = 0;
   bit  cmp_en  = 1'b0;

   responder_arbiter #(
      .TICK_DIV(TD), .DEB_MS(DEB), .PLAY_MS(PLY), .TICKS_PER_S(TPS), .WINDOW_S(WIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .player_btn(player_btn), .play_en(play_en), .winner(winner),
      .winner_valid(winner_valid), .armed(armed), .timeout(timeout),
      .countdown(countdown), .false_start(false_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_check++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------- round-level model
   typedef enum {M_IDLE, M_ARMED, M_WON, M_DONE, M_TOUT} m_state_t;

   m_state_t   m_state;
   int         m_cyc, m_sec_ticks, m_play_ticks;
   int         m_run [6];
   logic [5:0] m_pipe [2];
   logic [5:0] m_level, m_level_prev;
   logic [3:0] m_winner, m_cd, m_fs;

   task automatic model_reset();
      m_state = M_IDLE; m_cyc = 0; m_sec_ticks = 0; m_play_ticks = 0;
      m_pipe[0] = '0; m_pipe[1] = '0; m_level = '0; m_level_prev = '0;
      m_winner = '0; m_cd = '0; m_fs = '0;
      for (int i = 0; i < 6; i++) m_run[i] = 0;
   endtask

   task automatic model_arm();
      m_state = M_ARMED; m_cd = 4'(WIN); m_sec_ticks = 0; m_winner = '0;
   endtask

   task automatic model_step();
      bit         tk;
      logic [5:0] seen, rises;
      logic [3:0] cand;
      tk = (m_cyc % TD) == TD - 1;
      m_cyc++;
      seen      = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {btn_clear, btn_start, player_btn};
      rises        = m_level & ~m_level_prev;
      m_level_prev = m_level;
      for (int i = 0; i < 6; i++) begin
         if (seen[i] == m_level[i]) m_run[i] = 0;
         else if (tk) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_level[i] = seen[i]; m_run[i] = 0; end
         end
      end
      if (rises[5]) begin
         m_state = M_IDLE; m_winner = '0; m_cd = '0; m_fs = '0;
      end else begin
         case (m_state)
            M_IDLE: begin
`ifdef RESPONDER_FALSE_START_EN
               m_fs = m_fs | rises[3:0];
`endif
               if (rises[4]) model_arm();
            end
            M_ARMED: begin
               cand = rises[3:0] & ~m_fs;
               if (cand != 0) begin
                  for (int p = 3; p >= 0; p--) if (cand[p]) m_winner = 4'(1 << p);
                  m_state = M_WON; m_play_ticks = 0;
               end else if (tk) begin
                  m_sec_ticks++;
                  if (m_sec_ticks == TPS) begin
                     m_sec_ticks = 0; m_cd = m_cd - 4'd1;
                     if (m_cd == 0) m_state = M_TOUT;
                  end
               end
            end
            M_WON: if (tk) begin
               m_play_ticks++;
               if (m_play_ticks == PLY) m_state = M_DONE;
            end
            default: if (rises[4]) model_arm();
         endcase
      end
   endtask

   function automatic logic [15:0] exp_vec();
      return {m_state == M_WON, m_winner, m_state inside {M_WON, M_DONE},
              m_state == M_ARMED, m_state == M_TOUT, m_cd, m_fs};
   endfunction

   logic [15:0] dut_vec;
   assign dut_vec = {play_en, winner, winner_valid, armed, timeout, countdown, false_start};

   initial forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) check("cycle_outputs", dut_vec, exp_vec());
   end

   // ---------------------------------------------------------------- stimulus helpers
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_all();
      btn_start = 1'b0; btn_clear = 1'b0; player_btn = '0;
   endtask

   task automatic do_clear();
      release_all(); cyc(40);
      btn_clear = 1'b1; cyc(40);
      btn_clear = 1'b0; cyc(40);
   endtask

   task automatic do_start();
      bit ok = 1'b0;
      btn_start = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         cyc(1);
         if (m_state == M_ARMED) ok = 1'b1;
      end
      check("start_arms", ok, 1);
      check("armed_out", armed, 1);
      check("cd_loaded", countdown, 4'd3);
      btn_start = 1'b0;
   endtask

   // ---------------------------------------------------------------- scenarios
   initial begin
      int         hi, rises_seen;
      bit         pe_seen, done, seen_pe, prev_wv;
      int         t_last;
      logic [3:0] vals [$];
      int         gaps [$];

      rst_n = 1'b0; release_all();
      player_btn = 4'b0010;          // held through reset
      cyc(4);
      cmp_en = 1'b1;
      check("reset_outputs", dut_vec, 16'h0000);

      rst_n = 1'b1; cyc(60);
      check("held_btn_idle_armed", armed, 0);
      check("held_btn_idle_valid", winner_valid, 0);
      do_clear();

      // player 2 wins, song plays PLAY_MS ticks, then DONE holds the winner
      do_start();
      player_btn = 4'b0100; hi = 0;
      for (int i = 0; i < 120; i++) begin
         cyc(1);
         if (play_en) hi++;
         if (i == 39) begin
            check("p2_winner", winner, 4'b0100);
            check("p2_valid", winner_valid, 1);
            player_btn = '0;
         end
      end
      check("p2_play_len", (hi >= TD * (PLY - 1) + 1) && (hi <= TD * PLY), 1);
      check("done_winner", winner, 4'b0100);
      check("done_valid", winner_valid, 1);
      check("done_play", play_en, 0);

      // simultaneous players 1 and 3
      do_clear(); do_start();
      player_btn = 4'b1010; cyc(40);
      check("tie_winner", winner, 4'b0010);

      // no press: 3,2,1 then timeout
      do_clear(); do_start();
      vals.delete(); gaps.delete();
      vals.push_back(countdown); t_last = 0; pe_seen = 0; done = 0;
      for (int i = 1; i <= 200 && !done; i++) begin
         cyc(1);
         if (play_en) pe_seen = 1;
         if (countdown != vals[$]) begin
            vals.push_back(countdown); gaps.push_back(i - t_last); t_last = i;
         end
         if (timeout) done = 1;
      end
      check("tout_reached", done, 1);
      check("tout_steps", vals.size(), 4);
      if (vals.size() == 4) begin
         check("cd_seq1", vals[1], 4'd2);
         check("cd_seq2", vals[2], 4'd1);
         check("cd_seq3", vals[3], 4'd0);
         check("cd_gap2", gaps[1], TD * TPS);
         check("cd_gap3", gaps[2], TD * TPS);
      end
      check("tout_cd", countdown, 0);
      check("tout_play_never", pe_seen, 0);

      // glitch rejected, bounce then stable press gives one winner event
      do_clear(); do_start();
      cyc(5);
      player_btn[0] = 1'b1; cyc(1); player_btn[0] = 1'b0; cyc(30);
      check("glitch_no_win", winner_valid, 0);
      check("glitch_still_armed", armed, 1);
      for (int i = 0; i < 5; i++) begin player_btn[0] = ~player_btn[0]; cyc(1); end
      player_btn[0] = 1'b1;
      rises_seen = 0; prev_wv = winner_valid;
      for (int i = 0; i < 80; i++) begin
         cyc(1);
         if (winner_valid && !prev_wv) rises_seen++;
         prev_wv = winner_valid;
      end
      check("bounce_one_event", rises_seen, 1);
      check("bounce_winner", winner, 4'b0001);

      // clear during play
      do_clear(); do_start();
      player_btn = 4'b1000; seen_pe = 0;
      for (int i = 0; i < 60 && !seen_pe; i++) begin cyc(1); seen_pe = play_en; end
      check("clr_play_started", seen_pe, 1);
      btn_clear = 1'b1; done = 0;
      for (int i = 0; i < 60 && !done; i++) begin cyc(1); done = !play_en; end
      check("clr_play_stopped", done, 1);
      check("clr_winner", winner, 0);
      check("clr_valid", winner_valid, 0);
      btn_clear = 1'b0;

`ifdef RESPONDER_FALSE_START_EN
      do_clear();
      player_btn = 4'b0001; cyc(40);
      check("fs_flag", false_start, 4'b0001);
      player_btn = '0; cyc(40);
      do_start();
      player_btn = 4'b0001; cyc(40);
      check("fs_ignored", winner_valid, 0);
      player_btn = 4'b0011; cyc(40);
      check("fs_p1_wins", winner, 4'b0010);
      check("fs_persist", false_start, 4'b0001);
`endif

      // random presses, occasional reset
      do_clear();
      for (int it = 0; it < 70; it++) begin
         int r;
         r = $urandom_range(0, 19);
         release_all();
         if (r == 0) btn_clear = 1'b1;
         else if (r < 6) btn_start = 1'b1;
         else if (r == 6) begin
            rst_n = 1'b0; cyc(3); rst_n = 1'b1;
         end else player_btn = 4'($urandom_range(0, 15));
         cyc($urandom_range(1, 60));
      end

      release_all(); cyc(5);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
